// File: rtl/or_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined OR tree.
// The bench uses the same helpers to derive the expected latency.
package or_tree_pkg;

  localparam int MAX_WIDTH = 256;
  localparam int MAX_ARITY = 8;

  function automatic int ipow(input int base, input int exp);
    int r;
    r = 1;
    for (int i = 0; i < exp; i++) begin
      r = r * base;
    end
    return r;
  endfunction

  // Smallest L >= 1 with base^L >= value; this is also the pipeline latency.
  function automatic int ceil_log(input int base, input int value);
    int l;
    int p;
    l = 1;
    p = base;
    while (p < value) begin
      p = p * base;
      l = l + 1;
    end
    return l;
  endfunction

  // Bit offset of tree level k when all levels are packed LSB-first into one vector.
  function automatic int level_offset(input int arity, input int pad_w, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off = off + pad_w / ipow(arity, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/or_tree_pipelined_level.sv
// One registered level of the OR tree: IN_BITS/ARITY nodes, each registering
// the OR of ARITY consecutive input bits, plus the matching valid register.
module or_tree_level
  import or_tree_pkg::*;
#(
  parameter int IN_BITS = 9,
  parameter int ARITY   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_BITS-1:0]         in,
  input  logic                       in_valid,
  output logic [IN_BITS/ARITY-1:0]   out,
  output logic                       out_valid
);

  localparam int NODES = IN_BITS / ARITY;

  logic [NODES-1:0] node_or;

  // Combinational fan-in for every node of this level.
  always_comb begin
    node_or = '0;
    for (int n = 0; n < NODES; n++) begin
      node_or[n] = |in[n*ARITY +: ARITY];
    end
  end

  // Data advances every cycle regardless of valid; only the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= node_or;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/or_tree_pipelined.sv
// Parametrised N-input OR reduction as a registered ARITY-way tree with a
// valid pipeline and a sticky "any seen" flag (set wins over clear).
module or_tree_pipelined
  import or_tree_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ARITY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             out,
  output logic             out_valid,
  input  logic             sticky_clr,
  output logic             sticky
);

  localparam int LEVELS = ceil_log(ARITY, WIDTH);
  localparam int PAD_W  = ipow(ARITY, LEVELS);
  localparam int TREE_W = level_offset(ARITY, PAD_W, LEVELS + 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || ARITY < 2 || ARITY > MAX_ARITY) begin : g_bad_param
    $error("or_tree_pipelined: WIDTH/ARITY out of legal range");
  end

  // All levels packed LSB-first: level 0 is the zero-padded input, the MSB is the root.
  wire [TREE_W-1:0] tree;
  wire [LEVELS:0]   valid_chain;

  assign tree[PAD_W-1:0] = PAD_W'(in);
  assign valid_chain[0]  = in_valid;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int IN_W    = PAD_W / ipow(ARITY, k - 1);
    localparam int IN_OFF  = level_offset(ARITY, PAD_W, k - 1);
    localparam int OUT_OFF = level_offset(ARITY, PAD_W, k);

    or_tree_level #(
      .IN_BITS (IN_W),
      .ARITY   (ARITY)
    ) u_level (
      .clk       (clk),
      .reset     (reset),
      .in        (tree[IN_OFF +: IN_W]),
      .in_valid  (valid_chain[k-1]),
      .out       (tree[OUT_OFF +: IN_W/ARITY]),
      .out_valid (valid_chain[k])
    );
  end

  assign out       = tree[TREE_W-1];
  assign out_valid = valid_chain[LEVELS];

  // Sticky flag: a qualifying result outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky <= 1'b0;
    end else if (out_valid && out) begin
      sticky <= 1'b1;
    end else if (sticky_clr) begin
      sticky <= 1'b0;
    end else begin
      sticky <= sticky;
    end
  end

endmodule
